axi4_write_arbiter: RTL and testbench

//  Round-robin arbiter that shares one single-beat AXI4 write path (AW/W/B) between
//  NUM_REQ on-chip requesters (cores / NoC endpoints) in front of the axi4 slave.

---
 rtl/axi4_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_axi4_write_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_write_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 write path (AW/W/B) between
// NUM_REQ requesters; one transaction outstanding at a time.
module axi4_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_wstrb,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [NUM_REQ-1:0]               req_done,
   output logic [1:0]                       req_bresp,
   output logic [ADDR_WIDTH-1:0]            awaddr,
   output logic                             awvalid,
   input  logic                             awready,
   output logic [DATA_WIDTH-1:0]            wdata,
   output logic [DATA_WIDTH/8-1:0]          wstrb,
   output logic                             wvalid,
   input  logic                             wready,
   input  logic [1:0]                       bresp,
   input  logic                             bvalid,
   output logic                             bready
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

   state_t                 state_q, state_d;
   logic [GW-1:0]          last_q, last_d;
   logic [GW-1:0]          gnt_q, gnt_d;
   logic                   awvalid_q, awvalid_d;
   logic                   wvalid_q, wvalid_d;
   logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [STRB_W-1:0]      wstrb_q, wstrb_d;
   logic [NUM_REQ-1:0]     ready_q, ready_d;
   logic [NUM_REQ-1:0]     done_q, done_d;
   logic [1:0]             bresp_q, bresp_d;

   logic [GW-1:0]          rr_idx;
   logic [GW-1:0]          pick;
   logic                   pick_vld;

   // Rotating search: first requester above the last completed grant, wrapping.
   always_comb begin
      rr_idx   = '0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         rr_idx = GW'((int'(last_q) + k) % NUM_REQ);
         if (!pick_vld && req_valid[rr_idx]) begin
            pick_vld = 1'b1;
            pick     = rr_idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      ready_d   = '0;
      done_d    = '0;
      bresp_d   = bresp_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               gnt_d     = pick;
               awaddr_d  = req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d   = req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
               wstrb_d   = req_wstrb[int'(pick)*STRB_W +: STRB_W];
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               ready_d   = NUM_REQ'(1) << pick;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            // AW and W retire independently; move on once neither is still pending.
            awvalid_d = awvalid_q & ~awready;
            wvalid_d  = wvalid_q & ~wready;
            if (!awvalid_d && !wvalid_d) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (bvalid) begin
               done_d  = NUM_REQ'(1) << gnt_q;
               bresp_d = bresp;
               last_d  = gnt_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         last_q    <= GW'(NUM_REQ - 1);
         gnt_q     <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         ready_q   <= '0;
         done_q    <= '0;
         bresp_q   <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         gnt_q     <= gnt_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         bresp_q   <= bresp_d;
      end
   end

   assign awvalid   = awvalid_q;
   assign wvalid    = wvalid_q;
   assign awaddr    = awaddr_q;
   assign wdata     = wdata_q;
   assign wstrb     = wstrb_q;
   assign req_ready = ready_q;
   assign req_done  = done_q;
   assign req_bresp = bresp_q;
   assign bready    = (state_q == RESP);

endmodule

// File: tb/tb_axi4_write_arbiter.sv
// Bench for axi4_write_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_axi4_write_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N*SW-1:0] req_wstrb;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_done;
   logic [1:0]      req_bresp;
   logic [AW-1:0]   awaddr;
   logic            awvalid;
   logic            awready;
   logic [DW-1:0]   wdata;
   logic [SW-1:0]   wstrb;
   logic            wvalid;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;

   always #5 clk = ~clk;

   axi4_write_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .req_ready(req_ready), .req_done(req_done), .req_bresp(req_bresp),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int ndone = 0;
   int glog[$];
   int dtime[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
      end
   endtask

   // Reference model: one open transaction record; expected outputs after each edge.
   int           m_busy, m_g, m_last;
   logic         e_awvalid, e_wvalid, e_bready;
   logic [AW-1:0] e_awaddr;
   logic [DW-1:0] e_wdata;
   logic [SW-1:0] e_wstrb;
   logic [N-1:0]  e_ready, e_done;
   logic [1:0]    e_bresp;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 0; m_g = 0; m_last = N - 1;
         e_awvalid = 0; e_wvalid = 0; e_bready = 0;
         e_awaddr = '0; e_wdata = '0; e_wstrb = '0;
         e_ready = '0; e_done = '0; e_bresp = '0;
      end else begin
         e_ready = '0;
         e_done  = '0;
         if (m_busy == 0) begin
            for (int k = 1; k <= N; k++) begin
               if (m_busy == 0 && req_valid[(m_last + k) % N]) begin
                  m_busy = 1;
                  m_g    = (m_last + k) % N;
               end
            end
            if (m_busy != 0) begin
               e_awaddr  = req_addr[m_g*AW +: AW];
               e_wdata   = req_wdata[m_g*DW +: DW];
               e_wstrb   = req_wstrb[m_g*SW +: SW];
               e_awvalid = 1; e_wvalid = 1;
               e_ready   = N'(1 << m_g);
            end
         end else if (e_awvalid || e_wvalid) begin
            if (awready) e_awvalid = 0;
            if (wready)  e_wvalid  = 0;
         end else if (bvalid) begin
            e_done  = N'(1 << m_g);
            e_bresp = bresp;
            m_last  = m_g;
            m_busy  = 0;
         end
         e_bready = (m_busy != 0) && !e_awvalid && !e_wvalid;
      end
   end

   always @(negedge clk) begin
      cyc++;
      chk("awvalid", awvalid, e_awvalid);
      chk("wvalid", wvalid, e_wvalid);
      chk("awaddr", awaddr, e_awaddr);
      chk("wdata", wdata, e_wdata);
      chk("wstrb", wstrb, e_wstrb);
      chk("req_ready", req_ready, e_ready);
      chk("req_done", req_done, e_done);
      chk("req_bresp", req_bresp, e_bresp);
      chk("bready", bready, e_bready);
      for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(i);
      if (req_done != '0) begin
         ndone++;
         dtime.push_back(cyc);
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_payload(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [SW-1:0] s);
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
      req_wstrb[i*SW +: SW] = s;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, nd0;
      int exp6[3];
      reset = 1'b1;
      req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
      repeat (2) tick();
      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_done", req_done, 0);
      chk("rst_bready", bready, 0);
      reset = 1'b0;
      tick();

      // 1: single request from requester 0
      set_payload(0, 32'h100, 32'hDEADBEEF, 4'hF);
      req_valid = 4'b0001;
      tick();
      chk("t1_awvalid", awvalid, 1);
      chk("t1_wvalid", wvalid, 1);
      chk("t1_awaddr", awaddr, 32'h100);
      chk("t1_wdata", wdata, 32'hDEADBEEF);
      chk("t1_ready", req_ready, 4'b0001);
      req_valid = '0;
      tick();
      chk("t1_bready", bready, 1);
      chk("t1_nodone", req_done, 0);
      tick();
      chk("t1_done", req_done, 4'b0001);
      chk("t1_bresp", req_bresp, 2'b00);
      tick();

      // 2: all requesters held high for 8 transactions
      do_reset();
      glog.delete(); dtime.delete();
      for (int i = 0; i < N; i++) set_payload(i, 32'h1000 + 32'(i*16), 32'h11111111 * 32'(i+1), 4'(i+1));
      req_valid = 4'b1111;
      cnt = 0;
      for (int t = 0; t < 60 && cnt < 8; t++) begin
         tick();
         if (req_done != '0) cnt++;
      end
      req_valid = '0;
      repeat (3) tick();
      chk("t2_ndone", cnt, 8);
      chk("t2_ngrant", glog.size(), 8);
      for (int i = 0; i < 8; i++) chk("t2_grant", (i < glog.size()) ? glog[i] : -1, i % 4);
      for (int i = 1; i < 8; i++)
         chk("t2_spacing", (i < dtime.size()) ? dtime[i] - dtime[i-1] : -1, 3);

      // 3: awready delayed, wready immediate
      do_reset();
      awready = 1'b0; wready = 1'b1; bvalid = 1'b1;
      set_payload(1, 32'h20000040, 32'hCAFEF00D, 4'h3);
      req_valid = 4'b0010;
      tick();
      chk("t3_ready", req_ready, 4'b0010);
      chk("t3_aw1", awvalid, 1);
      chk("t3_w1", wvalid, 1);
      req_valid = '0;
      tick();
      chk("t3_w_drop", wvalid, 0);
      chk("t3_aw2", awvalid, 1);
      chk("t3_addr2", awaddr, 32'h20000040);
      tick();
      chk("t3_aw3", awvalid, 1);
      chk("t3_nobready3", bready, 0);
      tick();
      chk("t3_aw4", awvalid, 1);
      chk("t3_addr4", awaddr, 32'h20000040);
      chk("t3_nobready4", bready, 0);
      awready = 1'b1;
      tick();
      chk("t3_aw_drop", awvalid, 0);
      chk("t3_bready", bready, 1);
      tick();
      chk("t3_done", req_done, 4'b0010);
      tick();

      // 4: bvalid delayed 5 cycles with SLVERR
      awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b10;
      set_payload(2, 32'h300, 32'h0BADF00D, 4'hC);
      nd0 = ndone;
      req_valid = 4'b0100;
      tick();
      chk("t4_ready", req_ready, 4'b0100);
      req_valid = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_bready_held", bready, 1);
         chk("t4_nodone", req_done, 0);
      end
      bvalid = 1'b1;
      tick();
      chk("t4_done", req_done, 4'b0100);
      chk("t4_bresp", req_bresp, 2'b10);
      bvalid = 1'b0; bresp = 2'b00;
      tick();
      chk("t4_done_pulse", req_done, 0);
      chk("t4_bresp_held", req_bresp, 2'b10);
      chk("t4_bready_off", bready, 0);
      repeat (3) tick();
      chk("t4_ndone", ndone - nd0, 1);

      // 5: reset in ADDR with awvalid high; bvalid high outside RESP is ignored
      awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
      set_payload(3, 32'h400, 32'h55AA55AA, 4'h5);
      req_valid = 4'b1000;
      tick();
      chk("t5_ready", req_ready, 4'b1000);
      chk("t5_aw", awvalid, 1);
      req_valid = '0;
      tick();
      nd0 = ndone;
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_aw", awvalid, 0);
      chk("t5_rst_w", wvalid, 0);
      chk("t5_rst_addr", awaddr, 0);
      chk("t5_rst_data", wdata, 0);
      chk("t5_rst_bready", bready, 0);
      repeat (2) tick();
      reset = 1'b0;
      awready = 1'b1; wready = 1'b1;
      glog.delete();
      req_valid = 4'b1001;
      tick();
      chk("t5_regrant0", req_ready, 4'b0001);
      req_valid = '0;
      repeat (6) tick();
      chk("t5_ndone", ndone - nd0, 1);
      chk("t5_ngrant", glog.size(), 1);

      // 6: requester 2 alone, then 1 and 3 together
      do_reset();
      glog.delete();
      set_payload(1, 32'h510, 32'h01010101, 4'h1);
      set_payload(2, 32'h520, 32'h02020202, 4'h2);
      set_payload(3, 32'h530, 32'h03030303, 4'h4);
      req_valid = 4'b0100;
      tick();
      req_valid = req_valid & ~req_ready;
      repeat (2) tick();
      req_valid = 4'b1010;
      for (int t = 0; t < 30 && req_valid != '0; t++) begin
         tick();
         req_valid = req_valid & ~req_ready;
      end
      repeat (4) tick();
      exp6 = '{2, 3, 1};
      chk("t6_ngrant", glog.size(), 3);
      for (int i = 0; i < 3; i++) chk("t6_grant", (i < glog.size()) ? glog[i] : -1, exp6[i]);

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
